// File: rtl/cla_seq_adder_ctrl.sv
// ---------------------------------------------------------------------------
// cla_seq_adder_ctrl
//
// Performs a WIDTH-bit addition by pushing one nibble per clock, LSB first,
// through a single 4-bit carry-lookahead slice. The carry between nibbles is
// held in a register. Operands are captured when start is accepted in IDLE,
// and the sum is assembled nibble by nibble in an output register.
//
// Optional feature: define SEQ_SUB_EN to add the 'sub' input. With sub=1,
// B is inverted at capture and the carry register is seeded with 1, so
// Sum = A - B mod 2^WIDTH and Cout=1 means no borrow.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset, highest priority
//   start    in   request, sampled only while idle
//   A, B     in   WIDTH-bit operands, captured on accepted start
//   Cin      in   carry into nibble 0, captured on accepted start
//   sub      in   (SEQ_SUB_EN only) subtract select, captured on start
//   busy     out  high while a sequence is running
//   done     out  one-cycle pulse when Sum/Cout are final
//   nib_idx  out  index of the nibble processed on the next edge
//   Sum      out  result register (partial during RUN)
//   Cout     out  carry out of the top nibble
// ---------------------------------------------------------------------------
module cla_seq_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic                 Cin,
`ifdef SEQ_SUB_EN
   input  logic                 sub,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [((WIDTH/4) > 1 ? $clog2(WIDTH/4) : 1)-1:0] nib_idx,
   output logic [WIDTH-1:0]     Sum,
   output logic                 Cout
);

   localparam int NIB   = WIDTH / 4;
   localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic               carry_q;
   logic [NIB_W-1:0]   idx_q;
   logic [WIDTH-1:0]   sum_q;
   logic               cout_q;
   logic               busy_q;
   logic               done_q;

   logic [3:0]         sliceA;
   logic [3:0]         sliceB;
   logic [3:0]         p;
   logic [3:0]         g;
   logic [4:0]         c;
   logic [3:0]         sum_d;
   logic               carry_d;

   // One 4-bit carry-lookahead slice fed by the current nibble of the
   // captured operands. Every carry is expanded into sum-of-products form so
   // no carry ripples through another carry term.
   always_comb begin
      sliceA = a_q[4*idx_q +: 4];
      sliceB = b_q[4*idx_q +: 4];
      p      = sliceA ^ sliceB;
      g      = sliceA & sliceB;
      c[0]   = carry_q;
      c[1]   = g[0] | (p[0] & c[0]);
      c[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
      c[4]   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
      sum_d   = p ^ c[3:0];
      carry_d = c[4];
   end

   // Sequencer: IDLE accepts a start and captures operands; RUN writes one
   // nibble per edge. done is a pulse, so it is cleared by default each cycle
   // and only set on the terminal RUN step.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= A;
`ifdef SEQ_SUB_EN
                  b_q     <= sub ? ~B : B;
                  carry_q <= sub ? 1'b1 : Cin;
`else
                  b_q     <= B;
                  carry_q <= Cin;
`endif
                  sum_q   <= '0;
                  cout_q  <= 1'b0;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               sum_q[4*idx_q +: 4] <= sum_d;
               carry_q             <= carry_d;
               if (idx_q == NIB_W'(NIB - 1)) begin
                  cout_q  <= carry_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  idx_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  idx_q <= idx_q + NIB_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               idx_q   <= '0;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign nib_idx = idx_q;
   assign Sum     = sum_q;
   assign Cout    = cout_q;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cla_seq_adder_ctrl
//
// Directed-vector bench for cla_seq_adder_ctrl (WIDTH=16). Inputs are driven
// and outputs sampled on the falling edge; the design acts on rising edges.
// Expected sums are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_cla_seq_adder_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic        Cin;
`ifdef SEQ_SUB_EN
   logic        sub;
`endif
   logic        busy;
   logic        done;
   logic [1:0]  nib_idx;
   logic [15:0] Sum;
   logic        Cout;

   int vectorCount;
   int missCount;

   cla_seq_adder_ctrl #(.WIDTH(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .A       (A),
      .B       (B),
      .Cin     (Cin),
`ifdef SEQ_SUB_EN
      .sub     (sub),
`endif
      .busy    (busy),
      .done    (done),
      .nib_idx (nib_idx),
      .Sum     (Sum),
      .Cout    (Cout)
   );

   // 10-unit clock; rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Present operands with start for one cycle, then wait (bounded) for done
   // and check latency, result, and that done lasts exactly one cycle.
   task automatic applyStimulus(input string tag, input logic [15:0] a,
                                input logic [15:0] b, input logic cin,
                                input logic subSel, input logic [15:0] expSum,
                                input logic expCout);
      int cycles;
      A     = a;
      B     = b;
      Cin   = cin;
`ifdef SEQ_SUB_EN
      sub   = subSel;
`else
      if (subSel) $display("[TB] note: subtract vector skipped in add-only build");
`endif
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput({tag, " busy after start"}, 32'(busy), 32'd1);
      cycles = 0;
      while (!done && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput({tag, " latency"}, cycles, 32'd4);
      checkOutput({tag, " sum"}, 32'(Sum), 32'(expSum));
      checkOutput({tag, " cout"}, 32'(Cout), 32'(expCout));
      checkOutput({tag, " busy at done"}, 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput({tag, " done pulse width"}, 32'(done), 32'd0);
      checkOutput({tag, " sum held"}, 32'(Sum), 32'(expSum));
   endtask

   initial begin
      int cycles;
      int doneSeen;
      vectorCount = 0;
      missCount   = 0;
      rst   = 1'b1;
      start = 1'b0;
      A     = 16'h0;
      B     = 16'h0;
      Cin   = 1'b0;
`ifdef SEQ_SUB_EN
      sub   = 1'b0;
`endif

      // Reset state
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset nib_idx", 32'(nib_idx), 32'd0);
      checkOutput("reset sum", 32'(Sum), 32'd0);
      checkOutput("reset cout", 32'(Cout), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic add and carry chains
      applyStimulus("add 1234+4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
      applyStimulus("add FFFF+0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
      applyStimulus("add FFFF+0+cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
      applyStimulus("add 8000+8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
      applyStimulus("add ABCD+1111", 16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0);

      // Start held high, operands changed mid-run, back-to-back on done
      A = 16'h1111; B = 16'h2222; Cin = 1'b0; start = 1'b1;
      @(negedge clk);
      A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1;
      cycles = 0;
      while (!done && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("held start latency", cycles, 32'd4);
      checkOutput("held start sum", 32'(Sum), 32'h3333);
      checkOutput("held start cout", 32'(Cout), 32'd0);
      A = 16'h0F0F; B = 16'h0101; Cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      checkOutput("b2b busy", 32'(busy), 32'd1);
      checkOutput("b2b sum cleared", 32'(Sum), 32'd0);
      cycles = 0;
      while (!done && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("b2b latency", cycles, 32'd4);
      checkOutput("b2b sum", 32'(Sum), 32'h1010);
      @(negedge clk);

      // Reset on the second RUN edge aborts the sequence
      A = 16'h1234; B = 16'h1111; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort done", 32'(done), 32'd0);
      checkOutput("abort sum", 32'(Sum), 32'd0);
      checkOutput("abort cout", 32'(Cout), 32'd0);
      checkOutput("abort nib_idx", 32'(nib_idx), 32'd0);
      doneSeen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) doneSeen++;
      end
      checkOutput("abort no done", doneSeen, 32'd0);

      // Partial observation after the first RUN edge
      A = 16'h00F8; B = 16'h0008; Cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checkOutput("partial nibble0", 32'(Sum[3:0]), 32'd0);
      checkOutput("partial nib_idx", 32'(nib_idx), 32'd1);
      checkOutput("partial carry", 32'(dut.carry_q), 32'd1);
      cycles = 1;
      while (!done && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("partial latency", cycles, 32'd4);
      checkOutput("partial sum", 32'(Sum), 32'h0100);
      checkOutput("partial cout", 32'(Cout), 32'd0);
      @(negedge clk);

`ifdef SEQ_SUB_EN
      applyStimulus("sub 5-7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
      applyStimulus("sub 7-5", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
      applyStimulus("sub0 add", 16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
